// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return address stack with per-branch checkpoint repair
module ras_ckpt #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = 3,
  parameter int CKPT_LOG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     addr_in,
  input  logic                 ckpt_save,
  input  logic [CKPT_LOG-1:0]  ckpt_save_id,
  input  logic                 ckpt_restore,
  input  logic [CKPT_LOG-1:0]  ckpt_restore_id,
  output logic [WIDTH-1:0]     top,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int NCKPT = 1 << CKPT_LOG;
  logic [WIDTH-1:0]     mem    [DEPTH];
  logic [DEPTH_LOG-1:0] ck_tos [NCKPT];
  logic [DEPTH_LOG:0]   ck_cnt [NCKPT];
  logic [WIDTH-1:0]     ck_top [NCKPT];
  logic [DEPTH_LOG-1:0] tos, nx_tos, wr_idx;
  logic [DEPTH_LOG:0]   count, nx_cnt;
  logic [WIDTH-1:0]     wr_data, nx_top;
  logic                 wr_en, nx_ovf, nx_unf;
  assign empty = count == '0;
  assign full  = count == (DEPTH_LOG+1)'(DEPTH);
  assign top   = empty ? '0 : mem[tos];
  always_comb begin
    nx_tos  = tos;
    nx_cnt  = count;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = addr_in;
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
    if (ckpt_restore) begin
      nx_tos  = ck_tos[ckpt_restore_id];
      nx_cnt  = ck_cnt[ckpt_restore_id];
      wr_en   = 1'b1;
      wr_idx  = ck_tos[ckpt_restore_id];
      wr_data = ck_top[ckpt_restore_id];
    end else if (push && (!pop || empty)) begin
      nx_tos  = tos + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = tos + 1'b1;
      nx_cnt  = full ? count : count + 1'b1;
      nx_ovf  = full;
    end else if (push) begin
      wr_en   = 1'b1;
    end else if (pop) begin
      nx_unf  = empty;
      nx_tos  = empty ? tos : tos - 1'b1;
      nx_cnt  = empty ? count : count - 1'b1;
    end
  end
  // snapshot sees this cycle's write to the new top before it lands in mem
  assign nx_top = (wr_en && wr_idx == nx_tos) ? wr_data : mem[nx_tos];
  always_ff @(posedge clk) begin
    if (rst) begin
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < NCKPT; i++) begin
        ck_tos[i] <= '0;
        ck_cnt[i] <= '0;
        ck_top[i] <= '0;
      end
    end else begin
      tos       <= nx_tos;
      count     <= nx_cnt;
      overflow  <= nx_ovf;
      underflow <= nx_unf;
      if (wr_en) mem[wr_idx] <= wr_data;
      if (ckpt_save) begin
        ck_tos[ckpt_save_id] <= nx_tos;
        ck_cnt[ckpt_save_id] <= nx_cnt;
        ck_top[ckpt_save_id] <= nx_top;
      end
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed vectors for ras_ckpt (DEPTH=4) against a behavioural stack model
module tb_ras_ckpt;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0, pop = 1'b0, ckpt_save = 1'b0, ckpt_restore = 1'b0;
  logic [31:0] addr_in = '0;
  logic [1:0]  ckpt_save_id = '0, ckpt_restore_id = '0;
  logic [31:0] top;
  logic        empty, full, overflow, underflow;
  int          errors = 0, checks = 0;
  bit          on = 1'b0;

  ras_ckpt #(.WIDTH(32), .DEPTH_LOG(2), .CKPT_LOG(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .addr_in(addr_in),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .top(top), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // reference model: 4-slot circular stack, pointer arithmetic modulo 4
  int m_mem [4];
  int m_tos, m_cnt;
  int c_tos [4], c_cnt [4], c_top [4];
  bit m_ovf, m_unf;

  always @(posedge clk) begin
    if (rst) begin
      m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < 4; i++) begin
        m_mem[i] = 0; c_tos[i] = 0; c_cnt[i] = 0; c_top[i] = 0;
      end
    end else begin
      m_ovf = 0;
      m_unf = 0;
      if (ckpt_restore) begin
        m_tos = c_tos[ckpt_restore_id];
        m_cnt = c_cnt[ckpt_restore_id];
        m_mem[m_tos] = c_top[ckpt_restore_id];
      end else if (push && pop && m_cnt > 0) begin
        m_mem[m_tos] = addr_in;
      end else if (push) begin
        m_ovf = (m_cnt == 4);
        m_tos = (m_tos + 1) % 4;
        m_mem[m_tos] = addr_in;
        if (m_cnt < 4) m_cnt++;
      end else if (pop) begin
        if (m_cnt == 0) m_unf = 1;
        else begin
          m_tos = (m_tos + 3) % 4;
          m_cnt--;
        end
      end
      if (ckpt_save) begin
        c_tos[ckpt_save_id] = m_tos;
        c_cnt[ckpt_save_id] = m_cnt;
        c_top[ckpt_save_id] = m_mem[m_tos];
      end
    end
  end

  always @(negedge clk) begin
    if (on) begin
      chk("model_top", top, (m_cnt == 0) ? 32'd0 : 32'(m_mem[m_tos]));
      chk("model_empty", 32'(empty), 32'(m_cnt == 0));
      chk("model_full", 32'(full), 32'(m_cnt == 4));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic pu, input logic po, input logic [31:0] a,
                     input logic sv, input logic [1:0] sid,
                     input logic rs, input logic [1:0] rid);
    push = pu; pop = po; addr_in = a;
    ckpt_save = sv; ckpt_save_id = sid;
    ckpt_restore = rs; ckpt_restore_id = rid;
    @(posedge clk);
    #1;
    push = 0; pop = 0; addr_in = '0; ckpt_save = 0; ckpt_restore = 0;
  endtask

  task automatic do_push(input logic [31:0] a); cyc(1, 0, a, 0, 0, 0, 0); endtask
  task automatic do_pop(); cyc(0, 1, 0, 0, 0, 0, 0); endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 0;
    on = 1;
    chk("rst_top", top, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    // basic push/pop
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("t1_top", top, 32'h300);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_full", 32'(full), 0);
    do_pop(); chk("t1_pop1", top, 32'h200);
    do_pop(); chk("t1_pop2", top, 32'h100);
    do_pop(); chk("t1_pop3", top, 0);
    chk("t1_empty_end", 32'(empty), 1);
    // overflow wraps over the oldest entry
    for (int i = 1; i <= 4; i++) do_push(32'(i));
    chk("t2_full4", 32'(full), 1);
    chk("t2_noovf4", 32'(overflow), 0);
    do_push(32'h5);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_full5", 32'(full), 1);
    for (int i = 5; i >= 2; i--) begin
      chk("t2_pop_top", top, 32'(i));
      do_pop();
      if (i == 5) chk("t2_ovf_once", 32'(overflow), 0);
    end
    chk("t2_empty", 32'(empty), 1);
    // underflow
    do_pop();
    chk("t3_unf", 32'(underflow), 1);
    chk("t3_empty", 32'(empty), 1);
    chk("t3_top", top, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t3_unf_once", 32'(underflow), 0);
    // wrong-path repair
    do_push(32'hA); do_push(32'hB);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, 32'hC, 0, 0, 0, 0);
    chk("t4_replace", top, 32'hC);
    do_pop();
    do_push(32'hD);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t4_restore", top, 32'hB);
    do_pop();
    chk("t4_after_pop", top, 32'hA);
    // save alongside push, then same-slot save+restore keeps the slot
    cyc(1, 0, 32'h44, 1, 2, 0, 0);
    do_push(32'h55); do_pop(); do_pop(); do_pop();
    cyc(0, 0, 0, 1, 2, 1, 2);
    chk("t5_restore", top, 32'h44);
    do_pop(); do_pop();
    cyc(0, 0, 0, 0, 0, 1, 2);
    chk("t5_same_slot", top, 32'h44);
    do_pop();
    chk("t5_pop", top, 32'hA);
    do_pop();
    chk("t5_empty", 32'(empty), 1);
    // never-saved slot with push ignored
    do_push(32'h66);
    cyc(1, 0, 32'h9, 0, 0, 1, 3);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_top", top, 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_unf", 32'(underflow), 0);
    // reset mid-operation
    do_push(32'h77);
    rst = 1;
    do_push(32'h7);
    rst = 0;
    chk("t7_empty", 32'(empty), 1);
    chk("t7_top", top, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t7_ckpt_cleared", 32'(empty), 1);
    @(posedge clk);
    #1;
    on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
